// File: rtl/parking_gate_detector_if.sv
// Sensor-side bundle of the parking gate detector: raw sensor levels in, filtered levels,
// direction pulses and busy flag out. master = sensor/consumer side, slave = detector.
interface parking_gate_detector_if;
    logic outer;
    logic inner;
    logic enter;
    logic exit;
    logic outer_q;
    logic inner_q;
    logic busy;

    modport master (
        output outer, inner,
        input  enter, exit, outer_q, inner_q, busy
    );

    modport slave (
        input  outer, inner,
        output enter, exit, outer_q, inner_q, busy
    );
endinterface

// File: rtl/parking_gate_detector.sv
// Photo-sensor synchronizer, optional debounce and car-direction FSM for the parking gate.
// Define PARKING_GATE_DEBOUNCE_EN to compile in the DEBOUNCE_CYCLES filters.
module parking_gate_detector #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    parking_gate_detector_if.slave  gate
);

    // Bit 1 = outer sensor, bit 0 = inner sensor throughout.
    logic [1:0] raw;
    logic [1:0] filt;

    assign raw = {gate.outer, gate.inner};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sensor
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= raw[gi];
                    sync_reg <= meta_reg;
                end
            end

`ifdef PARKING_GATE_DEBOUNCE_EN
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            logic [CW-1:0] cnt_reg;
            logic          q_reg;

            // Counter tracks consecutive disagreeing samples; any agreement restarts it.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg <= '0;
                    q_reg   <= 1'b0;
                end else if (sync_reg == q_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
                    q_reg   <= sync_reg;
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end

            assign filt[gi] = q_reg;
`else
            assign filt[gi] = sync_reg;
`endif
        end
    endgenerate

`ifndef PARKING_GATE_DEBOUNCE_EN
    logic [31:0] unused_cfg;
    assign unused_cfg = 32'(DEBOUNCE_CYCLES);
`endif

    typedef enum logic [2:0] {
        IDLE,
        IN_A,
        IN_B,
        IN_C,
        OUT_A,
        OUT_B,
        OUT_C,
        ABORT
    } state_t;

    state_t state_reg;
    state_t state_next;
    logic   enter_reg;
    logic   enter_next;
    logic   exit_reg;
    logic   exit_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            enter_reg <= 1'b0;
            exit_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            enter_reg <= enter_next;
            exit_reg  <= exit_next;
        end
    end

    // Patterns not listed for a state hold that state.
    always_comb begin
        state_next = state_reg;
        enter_next = 1'b0;
        exit_next  = 1'b0;
        unique case (state_reg)
            IDLE: begin
                case (filt)
                    2'b10:   state_next = IN_A;
                    2'b01:   state_next = OUT_A;
                    2'b11:   state_next = ABORT;
                    default: state_next = IDLE;
                endcase
            end
            IN_A: begin
                case (filt)
                    2'b11:   state_next = IN_B;
                    2'b00:   state_next = IDLE;
                    2'b01:   state_next = ABORT;
                    default: state_next = IN_A;
                endcase
            end
            IN_B: begin
                case (filt)
                    2'b01:   state_next = IN_C;
                    2'b10:   state_next = IN_A;
                    2'b00:   state_next = ABORT;
                    default: state_next = IN_B;
                endcase
            end
            IN_C: begin
                case (filt)
                    2'b00: begin
                        state_next = IDLE;
                        enter_next = 1'b1;
                    end
                    2'b11:   state_next = IN_B;
                    2'b10:   state_next = ABORT;
                    default: state_next = IN_C;
                endcase
            end
            OUT_A: begin
                case (filt)
                    2'b11:   state_next = OUT_B;
                    2'b00:   state_next = IDLE;
                    2'b10:   state_next = ABORT;
                    default: state_next = OUT_A;
                endcase
            end
            OUT_B: begin
                case (filt)
                    2'b10:   state_next = OUT_C;
                    2'b01:   state_next = OUT_A;
                    2'b00:   state_next = ABORT;
                    default: state_next = OUT_B;
                endcase
            end
            OUT_C: begin
                case (filt)
                    2'b00: begin
                        state_next = IDLE;
                        exit_next  = 1'b1;
                    end
                    2'b11:   state_next = OUT_B;
                    2'b01:   state_next = ABORT;
                    default: state_next = OUT_C;
                endcase
            end
            ABORT: begin
                if (filt == 2'b00) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign gate.enter   = enter_reg;
    assign gate.exit    = exit_reg;
    assign gate.outer_q = filt[1];
    assign gate.inner_q = filt[0];
    assign gate.busy    = (state_reg != IDLE);

endmodule

// File: doc/parking_gate_detector.md
# parking_gate_detector

Upstream sensor stage for the parking-lot occupancy counter. Takes the raw outer and inner photo-sensor levels from the LabsLand GPIO header and synchronizes and debounces them. Tracks each crossing with a direction state machine and emits a single-cycle `enter` or `exit` pulse only for a complete, correctly ordered car passage. Pedestrians, aborted passages and illegal jumps produce no pulse.

## Interface
- `DEBOUNCE_CYCLES`, default 4: number of consecutive cycles a synchronized sensor must differ from its filtered value before the filtered value changes. Legal range ≥1.
- `clk`  input  1  system clock (CLOCK_50 at top level)
- `reset`  input  1  synchronous, active-high reset, sampled on rising `clk`
- `outer`  input  1  raw outer sensor, 1 = blocked, asynchronous to `clk`
- `inner`  input  1  raw inner sensor, 1 = blocked, asynchronous to `clk`
- `enter`  output  1  one-cycle pulse: a car completed an inward passage
- `exit`  output  1  one-cycle pulse: a car completed an outward passage
- `outer_q`  output  1  filtered outer level
- `inner_q`  output  1  filtered inner level
- `busy`  output  1  high whenever FSM state ≠ IDLE

## Operation
- Synchronizer: two flops per sensor, producing `s_outer` and `s_inner`.
- Debounce, one instance per sensor:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - Counter clears whenever the synchronized value equals the filtered value.
  - Otherwise the counter increments. When it would reach DEBOUNCE_CYCLES, the filtered value takes the synchronized value and the counter clears.
- FSM input is the pattern P = {outer_q, inner_q}. States and transitions:
  - IDLE: 10→IN_A; 01→OUT_A; 11→ABORT; 00 stays.
  - IN_A: 11→IN_B; 00→IDLE; 01→ABORT.
  - IN_B: 01→IN_C; 10→IN_A; 00→ABORT.
  - IN_C: 00→IDLE and pulse `enter`; 11→IN_B; 10→ABORT.
  - OUT_A: 11→OUT_B; 00→IDLE; 10→ABORT.
  - OUT_B: 10→OUT_C; 01→OUT_A; 00→ABORT.
  - OUT_C: 00→IDLE and pulse `exit`; 11→OUT_B; 01→ABORT.
  - ABORT: 00→IDLE; any other pattern stays. No pulse is ever generated from ABORT.
- A pedestrian (outer blocked then released, then inner blocked then released) passes IDLE→IN_A→IDLE→OUT_A→IDLE and yields no pulse.
- Backing up one step is legal. A sequence that backs up and later completes still yields exactly one pulse.
- `enter` and `exit` are registered and mutually exclusive. Each completed passage gives exactly one pulse of one cycle.

## Timing
- Reset values: `enter`=0, `exit`=0, `outer_q`=0, `inner_q`=0, `busy`=0. State is IDLE; all synchronizer flops and counters are 0.
- Reset mid-sequence abandons the passage with no pulse.
- After reset deasserts, sensors that are still blocked are handled as fresh input from IDLE (11 goes to ABORT).
- Let edge 0 be the first `clk` edge that samples a new raw level.
  - `s_*` changes at edge 1.
  - With debounce, `*_q` changes at edge 1+DEBOUNCE_CYCLES. The state, `busy` and the pulse update at edge 2+DEBOUNCE_CYCLES.
- A raw glitch held for fewer than DEBOUNCE_CYCLES synchronized cycles never reaches `*_q`.
- Simultaneous change of both sensors is seen as one pattern change. Example: 10→01 from IN_A goes to ABORT.
- Pulses for back-to-back cars are separated by at least one full passage, so two pulses are never adjacent.

## Configuration
- `PARKING_GATE_DEBOUNCE_EN`
  - Defined: debounce filters are compiled in and behave as above.
  - Undefined: filters and counters are removed, and `*_q` = `s_*` directly. FSM update and pulse occur at edge 2, and DEBOUNCE_CYCLES is ignored.

## Test plan
- Reset: hold `reset` for 2 cycles with sensors at 00 → all outputs 0, `busy`=0.
- Car in, DEBOUNCE_CYCLES=4, each pattern held 10 cycles: outer/inner sequence 10,11,01,00 → `enter`=1 for exactly one cycle, at edge 6 after raw 00 is first sampled; `exit` stays 0.
- Car out: sequence 01,11,10,00 → one `exit` pulse; then pedestrian 10,00,01,00 → no pulse, `busy` returns to 0.
- Glitch: outer pulsed high for 3 cycles with DEBOUNCE_CYCLES=4 → `outer_q` stays 0, state stays IDLE.
- Back-up then complete: 10,11,10,11,01,00 → exactly one `enter`. Illegal jump 10,01,00 → ABORT, then IDLE, no pulse.
- Reset mid-passage: assert `reset` while in IN_C → no `enter`, state IDLE. Sensors then held at 11 → ABORT, `busy`=1 until 00.
